// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART capture monitor: parity modes,
// receiver FSM states and the clocks-per-bit calculation.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Below four clocks per bit the mid-bit sampling point is meaningless.
  localparam int MIN_CPB = 4;

  // Clocks per bit, truncated; the receiver resynchronises on every start bit.
  function automatic int calc_cpb(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART receiver: input synchroniser, framing FSM, shift register and
// per-character error detection. Emits one registered pulse per character.
module uart_rx_core #(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 10_000_000,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  output logic                 char_valid,
  output logic [DATA_BITS-1:0] char_data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 fsm_idle,
  output logic                 start_seen
);
  import uart_pkg::*;

  localparam int CPB = calc_cpb(CLOCK_FREQ, BAUD_RATE);
  localparam int CW  = $clog2(CPB) + 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(CPB / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CPB - 1);
  localparam parity_e PAR_MODE = parity_e'(PARITY);

  if (CPB < MIN_CPB) begin : g_cpb_check
    $error("uart_rx_core: CLOCK_FREQ/BAUD_RATE must be at least 4");
  end

  logic                 sync1_reg, sync2_reg;
  logic                 s;
  rx_state_e            state_reg, state_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic [3:0]           bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_bad_reg, par_bad_next;
  logic                 frame_bad_reg, frame_bad_next;
  logic                 char_valid_reg, frame_err_reg, parity_err_reg;
  logic [DATA_BITS-1:0] char_data_reg;
  logic                 tick, par_xor, par_mismatch;
  logic                 commit, commit_frame, start_evt;

  assign s        = sync2_reg;
  assign tick     = (cnt_reg == '0);
  assign par_xor  = (^shift_reg) ^ s;
  assign par_mismatch = (PAR_MODE == PAR_ODD) ? ~par_xor : par_xor;

  // Two-flop synchroniser, preset high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= serial_in;
      sync2_reg <= sync1_reg;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic plus bit timing, shifting and error accumulation.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = tick ? cnt_reg : cnt_reg - 1'b1;
    bit_next       = bit_reg;
    shift_next     = shift_reg;
    par_bad_next   = par_bad_reg;
    frame_bad_next = frame_bad_reg;
    commit         = 1'b0;
    commit_frame   = 1'b0;
    start_evt      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!s) begin
          state_next     = ST_START;
          cnt_next       = HALF_LOAD;
          bit_next       = '0;
          par_bad_next   = 1'b0;
          frame_bad_next = 1'b0;
          start_evt      = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          if (s) begin
            state_next = ST_IDLE;
          end else begin
            state_next = ST_DATA;
            cnt_next   = FULL_LOAD;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_next = {s, shift_reg[DATA_BITS-1:1]};
          cnt_next   = FULL_LOAD;
          if (bit_reg == 4'(DATA_BITS - 1)) begin
            bit_next   = '0;
            state_next = (PAR_MODE != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          par_bad_next = par_mismatch;
          cnt_next     = FULL_LOAD;
          state_next   = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          frame_bad_next = frame_bad_reg | ~s;
          if (bit_reg == 4'(STOP_BITS - 1)) begin
            commit       = 1'b1;
            commit_frame = frame_bad_reg | ~s;
            state_next   = (frame_bad_reg | ~s) ? ST_BREAK : ST_IDLE;
          end else begin
            bit_next = bit_reg + 1'b1;
            cnt_next = FULL_LOAD;
          end
        end
      end
      ST_BREAK: begin
        if (s) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath registers and the registered per-character outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg        <= '0;
      bit_reg        <= '0;
      shift_reg      <= '0;
      par_bad_reg    <= 1'b0;
      frame_bad_reg  <= 1'b0;
      char_valid_reg <= 1'b0;
      char_data_reg  <= '0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
    end else begin
      cnt_reg        <= cnt_next;
      bit_reg        <= bit_next;
      shift_reg      <= shift_next;
      par_bad_reg    <= par_bad_next;
      frame_bad_reg  <= frame_bad_next;
      char_valid_reg <= commit;
      frame_err_reg  <= commit & commit_frame;
      parity_err_reg <= commit & par_bad_reg;
      if (commit) char_data_reg <= shift_reg;
    end
  end

  assign char_valid = char_valid_reg;
  assign char_data  = char_data_reg;
  assign frame_err  = frame_err_reg;
  assign parity_err = parity_err_reg;
  assign fsm_idle   = (state_reg == ST_IDLE);
  assign start_seen = start_evt;

endmodule

// File: rtl/uart_capture_monitor.sv
// Capture monitor top: buffers received characters, keeps the count and the
// sticky done/timeout/error status around a uart_rx_core receiver.
module uart_capture_monitor #(
  parameter int CLOCK_FREQ     = 50_000_000,
  parameter int BAUD_RATE      = 10_000_000,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int DEPTH          = 256,
  parameter int EXPECT_CHARS   = 156,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       serial_in,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic [DATA_BITS-1:0]       rd_data,
  output logic [$clog2(DEPTH):0]     char_count,
  output logic                       char_valid,
  output logic [DATA_BITS-1:0]       char_data,
  output logic                       frame_err,
  output logic                       parity_err,
  output logic                       overflow,
  output logic                       done,
  output logic                       timeout
);
  import uart_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
    $error("uart_capture_monitor: DEPTH must be a power of two >= 2");
  end
  if ((EXPECT_CHARS < 1) || (EXPECT_CHARS > DEPTH)) begin : g_expect_check
    $error("uart_capture_monitor: EXPECT_CHARS must be in 1..DEPTH");
  end
  if (calc_cpb(CLOCK_FREQ, BAUD_RATE) < MIN_CPB) begin : g_rate_check
    $error("uart_capture_monitor: clocks per bit below minimum");
  end

  logic                 core_valid, core_frame, core_parity, fsm_idle, start_seen;
  logic [DATA_BITS-1:0] core_data;
  logic                 can_store;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [DATA_BITS-1:0] rd_data_reg;
  logic [CW-1:0]        count_reg;
  logic [IW-1:0]        idle_cnt_reg;
  logic                 frame_err_reg, parity_err_reg, overflow_reg;
  logic                 done_reg, timeout_reg;

  uart_rx_core #(
    .CLOCK_FREQ (CLOCK_FREQ),
    .BAUD_RATE  (BAUD_RATE),
    .DATA_BITS  (DATA_BITS),
    .PARITY     (PARITY),
    .STOP_BITS  (STOP_BITS)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .serial_in  (serial_in),
    .char_valid (core_valid),
    .char_data  (core_data),
    .frame_err  (core_frame),
    .parity_err (core_parity),
    .fsm_idle   (fsm_idle),
    .start_seen (start_seen)
  );

  assign can_store = core_valid && (count_reg < CW'(DEPTH));

  // Capture buffer write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (can_store) mem[count_reg[AW-1:0]] <= core_data;
  end

  // Registered read port; a same-cycle write is seen one cycle later.
  always_ff @(posedge clk) begin
    if (rst) rd_data_reg <= '0;
    else     rd_data_reg <= mem[rd_addr];
  end

  // Character count, sticky error flags and done.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg      <= '0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      if (core_frame)  frame_err_reg  <= 1'b1;
      if (core_parity) parity_err_reg <= 1'b1;
      if (core_valid && !can_store) overflow_reg <= 1'b1;
      if (can_store) begin
        count_reg <= count_reg + 1'b1;
        if ((count_reg == CW'(EXPECT_CHARS - 1)) && !timeout_reg) done_reg <= 1'b1;
      end
    end
  end

  // Idle interval counter; frozen once either terminal flag is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else if (!done_reg && !timeout_reg) begin
      if (core_valid || start_seen) begin
        idle_cnt_reg <= '0;
      end else if (fsm_idle) begin
        if (idle_cnt_reg == IW'(TIMEOUT_CYCLES - 1)) timeout_reg <= 1'b1;
        else                                         idle_cnt_reg <= idle_cnt_reg + 1'b1;
      end
    end
  end

  assign rd_data    = rd_data_reg;
  assign char_count = count_reg;
  assign char_valid = core_valid;
  assign char_data  = core_data;
  assign frame_err  = frame_err_reg;
  assign parity_err = parity_err_reg;
  assign overflow   = overflow_reg;
  assign done       = done_reg;
  assign timeout    = timeout_reg;

endmodule

// File: tb/tb_uart_capture_monitor.sv
// Scoreboard bench: stimulus pushes expected characters, per-instance monitors
// pop and compare on every char_valid. Instance A is 8N1, B is 8E1.
module tb_uart_capture_monitor;

  localparam int CPB = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ser_a = 1'b1, ser_b = 1'b1;
  logic [1:0] rd_addr_a = '0;
  logic [2:0] rd_addr_b = '0;
  logic [7:0] rd_data_a, char_data_a, rd_data_b, char_data_b;
  logic [2:0] count_a;
  logic [3:0] count_b;
  logic       valid_a, ferr_a, perr_a, ovf_a, done_a, to_a;
  logic       valid_b, ferr_b, perr_b, ovf_b, done_b, to_b;

  int checks = 0;
  int errors = 0;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];

  always #5 clk = ~clk;

  uart_capture_monitor #(
    .CLOCK_FREQ(50_000_000), .BAUD_RATE(10_000_000), .DATA_BITS(8), .PARITY(0),
    .STOP_BITS(1), .DEPTH(4), .EXPECT_CHARS(4), .TIMEOUT_CYCLES(50)
  ) dut_a (
    .clk(clk), .rst(rst), .serial_in(ser_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
    .char_count(count_a), .char_valid(valid_a), .char_data(char_data_a),
    .frame_err(ferr_a), .parity_err(perr_a), .overflow(ovf_a), .done(done_a), .timeout(to_a)
  );

  uart_capture_monitor #(
    .CLOCK_FREQ(50_000_000), .BAUD_RATE(10_000_000), .DATA_BITS(8), .PARITY(2),
    .STOP_BITS(1), .DEPTH(8), .EXPECT_CHARS(8), .TIMEOUT_CYCLES(1_000_000)
  ) dut_b (
    .clk(clk), .rst(rst), .serial_in(ser_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
    .char_count(count_b), .char_valid(valid_b), .char_data(char_data_b),
    .frame_err(ferr_b), .parity_err(perr_b), .overflow(ovf_b), .done(done_b), .timeout(to_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  // Scoreboard monitors: every char_valid must match the next expected character.
  always @(negedge clk) begin
    if (valid_a) begin
      if (q_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL char_a unexpected actual=0x%0h required=none", char_data_a);
      end else begin
        chk("char_a", char_data_a, q_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (valid_b) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL char_b unexpected actual=0x%0h required=none", char_data_b);
      end else begin
        chk("char_b", char_data_b, q_b.pop_front());
      end
    end
  end

  // Drive nbits of frame LSB first, CPB clocks per bit.
  task automatic send_frame(input bit sel_b, input logic [11:0] frame, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (sel_b) ser_b = frame[i];
      else       ser_a = frame[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic send_a(input logic [7:0] d);
    q_a.push_back(d);
    send_frame(1'b0, {2'b11, 1'b1, d, 1'b0}, 10);
    repeat (6) @(negedge clk);
  endtask

  task automatic send_b(input logic [7:0] d, input logic p);
    q_b.push_back(d);
    send_frame(1'b1, {1'b1, 1'b1, p, d, 1'b0}, 11);
    repeat (6) @(negedge clk);
  endtask

  task automatic read_a(input int addr, input int exp, input string name);
    rd_addr_a = 2'(addr);
    @(negedge clk);
    chk(name, rd_data_a, exp);
  endtask

  task automatic read_b(input int addr, input int exp, input string name);
    rd_addr_b = 3'(addr);
    @(negedge clk);
    chk(name, rd_data_b, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ser_a = 1'b1; ser_b = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int to_cycle;
    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_count_a", count_a, 0);
    chk("rst_flags_a", {valid_a, ferr_a, perr_a, ovf_a, done_a, to_a}, 0);
    chk("rst_rd_data_a", rd_data_a, 0);
    chk("rst_char_data_a", char_data_a, 0);
    rst = 1'b0;

    // Timeout with no traffic.
    to_cycle = 99;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (to_a) begin
        to_cycle = i;
        break;
      end
    end
    chk_range("timeout_cycle", to_cycle, 49, 51);
    chk("timeout_done_a", done_a, 0);

    // Single-cycle glitch on idle line.
    do_reset();
    ser_a = 1'b0;
    @(negedge clk);
    ser_a = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_count", count_a, 0);

    // Two characters, then read back.
    send_a(8'h41);
    send_a(8'h0A);
    chk("count_two", count_a, 2);
    chk("flags_two", {ferr_a, perr_a, ovf_a, done_a, to_a}, 0);
    read_a(0, 8'h41, "buf0");
    read_a(1, 8'h0A, "buf1");

    // Reach EXPECT_CHARS, then overflow the 4-entry buffer.
    send_a(8'h43);
    chk("done_before_4th", done_a, 0);
    send_a(8'h44);
    chk("done_at_4th", done_a, 1);
    chk("count_four", count_a, 4);
    send_a(8'h45);
    chk("overflow", ovf_a, 1);
    chk("count_sat", count_a, 4);
    read_a(0, 8'h41, "buf0_after_ovf");
    read_a(3, 8'h44, "buf3_after_ovf");
    repeat (120) @(negedge clk);
    chk("no_timeout_after_done", to_a, 0);

    // Reset in the middle of a character.
    ser_a = 1'b0;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_count", count_a, 0);
    chk("midrst_flags", {valid_a, ferr_a, perr_a, ovf_a, done_a, to_a}, 0);
    chk("midrst_char_data", char_data_a, 0);
    chk("midrst_rd_data", rd_data_a, 0);
    ser_a = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send_a(8'h5A);
    chk("post_rst_count", count_a, 1);
    read_a(0, 8'h5A, "post_rst_buf0");

    // Stop bit low, line held low: one commit only, then recovery.
    q_a.push_back(8'h33);
    send_frame(1'b0, {2'b00, 1'b0, 8'h33, 1'b0}, 10);
    repeat (100) @(negedge clk);
    chk("break_count", count_a, 2);
    chk("frame_err", ferr_a, 1);
    ser_a = 1'b1;
    repeat (5) @(negedge clk);
    send_a(8'h11);
    chk("after_break_count", count_a, 3);
    read_a(2, 8'h11, "after_break_buf2");

    // Even parity instance.
    send_b(8'h03, 1'b0);
    chk("par_ok_err", perr_b, 0);
    chk("par_ok_count", count_b, 1);
    send_b(8'h03, 1'b1);
    chk("par_bad_err", perr_b, 1);
    chk("par_bad_count", count_b, 2);
    read_b(1, 8'h03, "par_bad_buf1");
    send_b(8'h03, 1'b0);
    chk("par_sticky", perr_b, 1);
    chk("par_frame_err", ferr_b, 0);
    chk("par_count3", count_b, 3);

    repeat (10) @(negedge clk);
    chk("queue_a_drained", q_a.size(), 0);
    chk("queue_b_drained", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_capture_monitor.md
Name: uart_capture_monitor

Overview:
- Parametrised serial-line capture block: deserialises a UART TX line from the CPU (8N1 by default; configurable data bits, parity and stop bits) and stores each received character in a capture buffer.
- Flags framing, parity and overflow errors.
- Raises done after a programmable character count, or timeout after a programmable idle interval.
- Used in simulation harnesses and on-chip debug to log CPU console output; the buffer is readable by index.

Parameters:
- CLOCK_FREQ, 50_000_000: clk frequency in Hz.
- BAUD_RATE, 10_000_000: line rate in bit/s. CPB = CLOCK_FREQ/BAUD_RATE (integer division) must be >= 4; elaboration error otherwise.
- DATA_BITS, 8: payload bits per character, 5..9.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.
- DEPTH, 256: capture buffer entries, power of two.
- EXPECT_CHARS, 156: character count that raises done; 1..DEPTH.
- TIMEOUT_CYCLES, 1_000_000: idle clocks before timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- serial_in  in  1  UART line, idle high, asynchronous to clk
- rd_addr  in  $clog2(DEPTH)  buffer read index
- rd_data  out  DATA_BITS  buffer contents at rd_addr, registered
- char_count  out  $clog2(DEPTH)+1  characters stored, saturates at DEPTH
- char_valid  out  1  one-cycle pulse when a character completes
- char_data  out  DATA_BITS  last completed character, held until the next one
- frame_err  out  1  sticky: a stop bit was sampled low
- parity_err  out  1  sticky: parity mismatch
- overflow  out  1  sticky: a character arrived while the buffer was full
- done  out  1  sticky: char_count reached EXPECT_CHARS
- timeout  out  1  sticky: idle counter reached TIMEOUT_CYCLES before done

Behaviour:
- Reset values:
  - All outputs 0, including rd_data and char_data.
  - FSM in IDLE; bit and idle counters 0.
  - Synchroniser flops preset to 1.
  - Buffer contents undefined.
- Input path:
  - serial_in passes through a 2-flop synchroniser (s); s lags serial_in by 2 cycles.
  - All sampling below refers to s.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: s==0 -> START and load the bit counter with CPB/2-1.
- START: when the counter expires, sample s:
  - s==1 is a glitch -> IDLE, nothing recorded.
  - s==0 -> DATA, counter loaded with CPB-1.
- DATA:
  - One sample every CPB cycles, shifted in LSB first, DATA_BITS samples total.
  - Then -> PARITY if PARITY!=0, else -> STOP.
- PARITY:
  - One sample.
  - Odd parity requires the XOR of data and parity bit to be 1; even requires 0.
  - A mismatch sets parity_err.
- STOP:
  - STOP_BITS samples, CPB apart.
  - Any 0 sample sets frame_err and moves to BREAK after the character is committed.
  - Otherwise -> IDLE.
- BREAK: wait for s==1, then -> IDLE. This prevents a held-low line from producing spurious characters.
- Commit (cycle of the final stop sample):
  - char_valid pulses and char_data updates.
  - Characters with a framing or parity error are still stored.
  - If char_count < DEPTH: buffer[char_count] <= data and char_count increments.
  - Else: drop the character and set overflow.
- done: set on the cycle char_count becomes EXPECT_CHARS. Later characters are still captured.
- Idle counter:
  - Increments each cycle while the FSM is in IDLE.
  - Clears on every commit and when entering START.
  - Frozen once done or timeout is set.
  - Reaching TIMEOUT_CYCLES-1 with done==0 sets timeout.
  - done and timeout are mutually exclusive; whichever sets first wins.
- Read port:
  - rd_data <= buffer[rd_addr] every cycle (1-cycle latency).
  - A same-cycle write to the same address returns the old value.
- Latency: falling edge of serial_in to char_valid = 2 + CPB/2 + CPB*(DATA_BITS + (PARITY!=0) + STOP_BITS - 1) + CPB cycles, ±1 cycle.
- Reset mid-character: the FSM returns to IDLE next cycle and the partial character is discarded.

Decomposition:
- Shared package uart_pkg holds:
  - parity enum (PAR_NONE, PAR_ODD, PAR_EVEN).
  - FSM state enum.
  - CPB computation function.
- One natural sub-module: uart_rx_core (synchroniser, FSM, shift register, error bits; outputs char_valid/char_data/err pulses). The top level owns the buffer, counts, done and timeout.

Test Plan:
- CPB=5, 8N1, send 0x41 then 0x0A -> char_valid twice; buffer[0]=0x41, buffer[1]=0x0A; char_count=2; no error flags.
- EXPECT_CHARS=4, send "ABCD" -> done rises on the 4th commit; timeout stays 0 after 2*TIMEOUT_CYCLES idle. Send 5 chars with DEPTH=4 -> overflow=1 and buffer unchanged.
- PARITY=2, send 0x03 with parity bit 1 -> parity_err=1, byte stored. Send 0x03 with parity bit 0 -> parity_err stays at its prior value.
- Stop bit forced 0, line held low 100 cycles -> exactly one commit, frame_err=1, FSM remains in BREAK until the line rises; no extra characters.
- 1-cycle low glitch on idle line -> no char_valid, char_count=0.
- TIMEOUT_CYCLES=50, no traffic -> timeout=1 at cycle 50±1. Assert rst mid-character -> all outputs 0 next cycle; a fresh character after reset is captured correctly.
